// File: rtl/max_pipe_pkg.sv
// Shared definitions for the pipelined max unit and its result buffer.
// Contents: default result width, result word type, valid/ready constants
// and a handshake helper.
package max_pipe_pkg;

  localparam int unsigned MAX_DATA_W = 8;

  typedef logic [MAX_DATA_W-1:0] max_data_t;

  localparam logic HS_ASSERT   = 1'b1;
  localparam logic HS_DEASSERT = 1'b0;

  // A transfer happens when both sides of a valid/ready pair agree.
  function automatic logic hs_fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/max_result_buffer_if.sv
// Valid/ready bundle between the max unit, the result buffer and its consumer.
// Signals:
//   in_val/in_data/in_rdy    producer side (max_val/max_data/max_rdy)
//   out_val/out_data/out_rdy consumer side
// Modports: master = producer+consumer environment, slave = the buffer.
interface max_result_buffer_if
  import max_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = MAX_DATA_W
);
  logic              in_val;
  logic [DATA_W-1:0] in_data;
  logic              in_rdy;
  logic              out_val;
  logic [DATA_W-1:0] out_data;
  logic              out_rdy;

  modport master (
    output in_val, in_data, out_rdy,
    input  in_rdy, out_val, out_data
  );

  modport slave (
    input  in_val, in_data, out_rdy,
    output in_rdy, out_val, out_data
  );
endinterface

// File: rtl/max_result_buffer_mem.sv
// max_buf_mem: DEPTH x DATA_W register array for the result buffer.
// Ports:
//   clk, rst_n                  clock, async active-low reset (clears storage)
//   wr_en, wr_ptr, wr_data      single synchronous write port
//   rd_ptr -> rd_data           single asynchronous read port
module max_buf_mem
  import max_pipe_pkg::*;
#(
  parameter  int unsigned DATA_W = MAX_DATA_W,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_ptr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_ptr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/max_result_buffer.sv
// max_result_buffer: FIFO stage after the pipelined max unit.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   bus          slave modport: in_val/in_data/in_rdy, out_val/out_data/out_rdy
//   level        occupancy 0..DEPTH
//   drop_cnt     saturating count of results offered while full
//   peak_clr     clear the peak tracker
//   peak_data    largest accepted result since reset/clear
//   peak_val     peak_data holds an accepted result
// Build option: MAX_RESULT_BUFFER_PEAK_HOLD_EN enables the peak tracker;
// without it peak_data/peak_val are tied to 0 and peak_clr is ignored.
module max_result_buffer
  import max_pipe_pkg::*;
#(
  parameter  int unsigned DATA_W = MAX_DATA_W,
  parameter  int unsigned DEPTH  = 4,
  parameter  int unsigned DROP_W = 8,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  max_result_buffer_if.slave  bus,
  output logic [LVL_W-1:0]    level,
  output logic [DROP_W-1:0]   drop_cnt,
  input  logic                peak_clr,
  output logic [DATA_W-1:0]   peak_data,
  output logic                peak_val
);

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  rd_sel;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [DATA_W-1:0] rd_data;
  logic              full, empty, push, pop;

  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);
  assign push  = hs_fire(bus.in_val, ~full);
  assign pop   = hs_fire(bus.out_rdy, ~empty);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (bus.in_val && full && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
    end
  end

  // While empty, show the slot behind the read pointer: it holds the last
  // popped word (or 0 after reset) and cannot be overwritten until a new
  // word has been pushed, so out_data holds its last value.
  assign rd_sel = empty ? (rd_ptr_q - PTR_W'(1)) : rd_ptr_q;

  max_buf_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_ptr  (wr_ptr_q),
    .wr_data (bus.in_data),
    .rd_ptr  (rd_sel),
    .rd_data (rd_data)
  );

  assign bus.in_rdy   = ~full;
  assign bus.out_val  = ~empty;
  assign bus.out_data = rd_data;
  assign level        = level_q;
  assign drop_cnt     = drop_q;

`ifdef MAX_RESULT_BUFFER_PEAK_HOLD_EN
  logic [DATA_W-1:0] peak_data_q, peak_data_d;
  logic              peak_val_q, peak_val_d;

  always_comb begin
    peak_data_d = peak_data_q;
    peak_val_d  = peak_val_q;
    if (peak_clr) begin
      peak_data_d = '0;
      peak_val_d  = HS_DEASSERT;
    end else if (push && (!peak_val_q || (bus.in_data > peak_data_q))) begin
      peak_data_d = bus.in_data;
      peak_val_d  = HS_ASSERT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_data_q <= '0;
      peak_val_q  <= HS_DEASSERT;
    end else begin
      peak_data_q <= peak_data_d;
      peak_val_q  <= peak_val_d;
    end
  end

  assign peak_data = peak_data_q;
  assign peak_val  = peak_val_q;
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign peak_data       = '0;
  assign peak_val        = HS_DEASSERT;
`endif

endmodule

// File: tb/tb_max_result_buffer.sv
// Self-checking bench for max_result_buffer (DEPTH=4, DATA_W=8, DROP_W=8).
// A queue-based reference model runs alongside the DUT and is compared
// on every falling edge; directed scenarios add literal expectations.
module tb_max_result_buffer;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DROP_W = 8;
  localparam int          DROP_MAX = (1 << DROP_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              peak_clr;
  logic [2:0]        level;
  logic [DROP_W-1:0] drop_cnt;
  logic [DATA_W-1:0] peak_data;
  logic              peak_val;

  int checks = 0;
  int failures = 0;

  max_result_buffer_if #(.DATA_W(DATA_W)) bus ();

  max_result_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .DROP_W (DROP_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .level     (level),
    .drop_cnt  (drop_cnt),
    .peak_clr  (peak_clr),
    .peak_data (peak_data),
    .peak_val  (peak_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents, last word handed out, drops, peak.
  int q[$];
  int m_last;
  int m_drops;
  int m_peak;
  bit m_peak_val;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_last = 0;
      m_drops = 0;
      m_peak = 0;
      m_peak_val = 0;
    end else begin
      bit room;
      bit did_push;
      room = (q.size() < DEPTH);
      did_push = 0;
      if (q.size() > 0 && bus.out_rdy) m_last = q.pop_front();
      if (bus.in_val) begin
        if (room) begin
          q.push_back(int'(bus.in_data));
          did_push = 1;
        end else if (m_drops < DROP_MAX) begin
          m_drops++;
        end
      end
`ifdef MAX_RESULT_BUFFER_PEAK_HOLD_EN
      if (peak_clr) begin
        m_peak = 0;
        m_peak_val = 0;
      end else if (did_push && (!m_peak_val || int'(bus.in_data) > m_peak)) begin
        m_peak = int'(bus.in_data);
        m_peak_val = 1;
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("level", level, q.size());
      chk("in_rdy", bus.in_rdy, q.size() < DEPTH);
      chk("out_val", bus.out_val, q.size() > 0);
      chk("out_data", bus.out_data, (q.size() > 0) ? q[0] : m_last);
      chk("drop_cnt", drop_cnt, m_drops);
      chk("peak_data", peak_data, m_peak);
      chk("peak_val", peak_val, m_peak_val);
    end
  end

  task automatic drive(input bit v, input int d, input bit r);
    bus.in_val  = v;
    bus.in_data = d[DATA_W-1:0];
    bus.out_rdy = r;
    @(negedge clk);
  endtask

  initial begin
    bus.in_val  = 1'b0;
    bus.in_data = '0;
    bus.out_rdy = 1'b0;
    peak_clr    = 1'b0;
    #1;
    chk("rst_level", level, 0);
    chk("rst_in_rdy", bus.in_rdy, 1);
    chk("rst_out_val", bus.out_val, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_drop", drop_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: three pushes while stalled, then drain in order
    drive(1, 'h12, 0);
    drive(1, 'h7F, 0);
    drive(1, 'h05, 0);
    bus.in_val = 1'b0;
    chk("t1_level3", level, 3);
    chk("t1_head", bus.out_data, 'h12);
    drive(0, 0, 1);
    chk("t1_second", bus.out_data, 'h7F);
    drive(0, 0, 1);
    chk("t1_third", bus.out_data, 'h05);
    drive(0, 0, 1);
    chk("t1_empty", level, 0);
    chk("t1_hold", bus.out_data, 'h05);

    // 2: fill, then three offers while full are dropped
    for (int i = 0; i < 4; i++) drive(1, 'hA0 + i, 0);
    for (int i = 0; i < 3; i++) drive(1, 'hEE, 0);
    bus.in_val = 1'b0;
    chk("t2_level", level, 4);
    chk("t2_in_rdy", bus.in_rdy, 0);
    chk("t2_drop", drop_cnt, 3);
    chk("t2_head", bus.out_data, 'hA0);

    // 3: level 2, simultaneous push/pop for 10 cycles
    drive(0, 0, 1);
    drive(0, 0, 1);
    chk("t3_level2", level, 2);
    for (int i = 0; i < 10; i++) drive(1, 'h30 + i, 1);
    bus.in_val = 1'b0;
    bus.out_rdy = 1'b0;
    chk("t3_level", level, 2);
    chk("t3_head", bus.out_data, 'h38);

    // 4: saturate the drop counter
    drive(1, 'h50, 0);
    drive(1, 'h51, 0);
    for (int i = 0; i < 300; i++) drive(1, 'h99, 0);
    bus.in_val = 1'b0;
    chk("t4_drop_sat", drop_cnt, 255);

    // 5: asynchronous reset with level 3
    drive(0, 0, 1);
    bus.out_rdy = 1'b0;
    chk("t5_level3", level, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_level", level, 0);
    chk("t5_out_val", bus.out_val, 0);
    chk("t5_out_data", bus.out_data, 0);
    chk("t5_in_rdy", bus.in_rdy, 1);
    chk("t5_drop", drop_cnt, 0);
    chk("t5_peak", peak_data, 0);
    chk("t5_peak_val", peak_val, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 'h5A, 0);
    bus.in_val = 1'b0;
    chk("t5_first_val", bus.out_val, 1);
    chk("t5_first_data", bus.out_data, 'h5A);
    drive(0, 0, 1);

    // 6: peak tracker
    drive(1, 'h40, 1);
    drive(1, 'hC3, 1);
    drive(1, 'h10, 1);
    bus.in_val = 1'b0;
`ifdef MAX_RESULT_BUFFER_PEAK_HOLD_EN
    chk("t6_peak", peak_data, 'hC3);
    chk("t6_peak_val", peak_val, 1);
`else
    chk("t6_peak", peak_data, 0);
    chk("t6_peak_val", peak_val, 0);
`endif
    peak_clr = 1'b1;
    drive(1, 'hFF, 1);
    peak_clr = 1'b0;
    bus.in_val = 1'b0;
    chk("t6_clr_val", peak_val, 0);
    chk("t6_clr_data", peak_data, 0);
    drive(1, 'h01, 1);
    bus.in_val = 1'b0;
`ifdef MAX_RESULT_BUFFER_PEAK_HOLD_EN
    chk("t6_new_peak", peak_data, 'h01);
    chk("t6_new_val", peak_val, 1);
`else
    chk("t6_new_peak", peak_data, 0);
    chk("t6_new_val", peak_val, 0);
`endif
    for (int i = 0; i < 4; i++) drive(0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
